// File: rtl/scoreboard_rf_if.sv
// Decode-side bus of the register-file scoreboard: read ports, issue and writeback.
interface scoreboard_rf_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRD    = 2
);
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD-1:0]        rd_use;
    logic [NRD*DATA_W-1:0] rd_data;
    logic                  iss_valid;
    logic                  iss_wrEn;
    logic [AW-1:0]         iss_rD;
    logic                  WB_wrEn;
    logic [AW-1:0]         WB_rD;
    logic [2:0]            WB_ppp;
    logic [DATA_W-1:0]     WB_rD_data;
    logic                  stall;
    logic                  sb_err;

    modport master (
        output rd_addr, rd_use, iss_valid, iss_wrEn, iss_rD,
               WB_wrEn, WB_rD, WB_ppp, WB_rD_data,
        input  rd_data, stall, sb_err
    );

    modport slave (
        input  rd_addr, rd_use, iss_valid, iss_wrEn, iss_rD,
               WB_wrEn, WB_rD, WB_ppp, WB_rD_data,
        output rd_data, stall, sb_err
    );
endinterface

// File: rtl/scoreboard_rf.sv
// Register file with byte-lane writeback, write-through reads and a per-register
// pending-write scoreboard that stalls decode on RAW hazards and counter saturation.
module scoreboard_rf #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NRD     = 2,
    parameter int unsigned R0_ZERO = 1
) (
    input logic            clk,
    input logic            reset,
    scoreboard_rf_if.slave sb
);
    localparam int unsigned NBYTE  = DATA_W / 8;
    localparam logic [AW:0] NREG_A = (AW+1)'(NREG);

    logic [DATA_W-1:0] regs    [NREG];
    logic [1:0]        cnt     [NREG];
    logic [1:0]        cnt_eff [NREG];
    logic [AW-1:0]     ra      [NRD];
    logic [DATA_W-1:0] rdv     [NRD];
    logic [NBYTE-1:0]  lane;
    logic [DATA_W-1:0] wmask;
    logic              sb_err_q;
    logic              wb_in_range;
    logic              wb_trk;
    logic              iss_trk;
    logic              iss_acc;
    logic              stall_c;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREG_A;
    endfunction

    // Register 0 is hardwired to zero when R0_ZERO is set, so it is neither stored nor tracked.
    function automatic logic tracked(input logic [AW-1:0] a);
        return in_range(a) && !((R0_ZERO != 0) && (a == '0));
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [DATA_W-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // Byte-lane mask; byte 0 is the most significant byte.
    always_comb begin
        lane  = '0;
        wmask = '0;
        for (int unsigned k = 0; k < NBYTE; k++) begin
            case (sb.WB_ppp)
                3'b000:  lane[k] = 1'b1;
                3'b001:  lane[k] = (k < NBYTE / 2);
                3'b010:  lane[k] = (k >= NBYTE / 2);
                3'b011:  lane[k] = ((k % 2) == 0);
                3'b100:  lane[k] = ((k % 2) == 1);
                default: lane[k] = 1'b0;
            endcase
            wmask[DATA_W-1-8*k -: 8] = {8{lane[k]}};
        end
    end

    // Effective count sees a same-cycle completion; never drops below zero.
    always_comb begin
        wb_in_range = in_range(sb.WB_rD);
        wb_trk      = sb.WB_wrEn && tracked(sb.WB_rD);
        iss_trk     = tracked(sb.iss_rD);
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_eff[r] = cnt[r];
            if (wb_trk && (sb.WB_rD == AW'(r)) && (cnt[r] != 2'd0)) begin
                cnt_eff[r] = cnt[r] - 2'd1;
            end
        end
    end

    always_comb begin
        stall_c    = 1'b0;
        sb.rd_data = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra[i]  = sb.rd_addr[(NRD-i)*AW-1 -: AW];
            rdv[i] = '0;
            if (tracked(ra[i])) begin
                rdv[i] = regs[ra[i]];
                if (wb_trk && (sb.WB_rD == ra[i])) begin
                    rdv[i] = merge(regs[ra[i]], sb.WB_rD_data, wmask);
                end
                if (sb.rd_use[NRD-1-i] && (cnt_eff[ra[i]] != 2'd0)) begin
                    stall_c = 1'b1;
                end
            end
            sb.rd_data[(NRD-i)*DATA_W-1 -: DATA_W] = rdv[i];
        end
        if (sb.iss_valid && sb.iss_wrEn && iss_trk && (cnt_eff[sb.iss_rD] == 2'd3)) begin
            stall_c = 1'b1;
        end
        iss_acc = sb.iss_valid && sb.iss_wrEn && iss_trk && !stall_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (iss_acc && (sb.iss_rD == AW'(r)) && !(wb_trk && (sb.WB_rD == AW'(r)))) begin
                    cnt[r] <= cnt[r] + 2'd1;
                end else if (wb_trk && (sb.WB_rD == AW'(r)) && !(iss_acc && (sb.iss_rD == AW'(r)))
                             && (cnt[r] != 2'd0)) begin
                    cnt[r] <= cnt[r] - 2'd1;
                end
            end
            if (wb_trk) begin
                regs[sb.WB_rD] <= merge(regs[sb.WB_rD], sb.WB_rD_data, wmask);
            end
            // Unexpected completion: out-of-range target or nothing pending.
            if (sb.WB_wrEn && (!wb_in_range || (wb_trk && (cnt[sb.WB_rD] == 2'd0)))) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign sb.stall  = stall_c;
    assign sb.sb_err = sb_err_q;
endmodule

// File: tb/tb_scoreboard_rf.sv
// Self-checking bench for scoreboard_rf: directed cycles push expectations, sampled on the falling edge.
module tb_scoreboard_rf;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned AW     = 5;
    localparam int unsigned NRD    = 2;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_STL  = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        string       tag;
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t expq[$];

    scoreboard_rf_if #(.DATA_W(DATA_W), .AW(AW), .NRD(NRD)) sbi ();

    scoreboard_rf #(
        .DATA_W(DATA_W), .NREG(32), .AW(AW), .NRD(NRD), .R0_ZERO(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sbi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic want(input int kind, input string tag, input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        expq.push_back(e);
    endtask

    // Compare pending expectations against the settled outputs, then commit the edge.
    task automatic step();
        exp_t        e;
        logic [63:0] act;
        @(negedge clk);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            case (e.kind)
                K_RD0:   act = sbi.rd_data[127:64];
                K_RD1:   act = sbi.rd_data[63:0];
                K_STL:   act = {63'd0, sbi.stall};
                default: act = {63'd0, sbi.sb_err};
            endcase
            check(e.tag, act, e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sbi.rd_addr    = '0;
        sbi.rd_use     = '0;
        sbi.iss_valid  = 1'b0;
        sbi.iss_wrEn   = 1'b0;
        sbi.iss_rD     = '0;
        sbi.WB_wrEn    = 1'b0;
        sbi.WB_rD      = '0;
        sbi.WB_ppp     = '0;
        sbi.WB_rD_data = '0;
    endtask

    task automatic rd(input int p, input logic [4:0] a, input logic u);
        if (p == 0) begin
            sbi.rd_addr[9:5] = a;
            sbi.rd_use[1]    = u;
        end else begin
            sbi.rd_addr[4:0] = a;
            sbi.rd_use[0]    = u;
        end
    endtask

    task automatic iss(input logic [4:0] d);
        sbi.iss_valid = 1'b1;
        sbi.iss_wrEn  = 1'b1;
        sbi.iss_rD    = d;
    endtask

    task automatic wb(input logic [4:0] d, input logic [2:0] p, input logic [63:0] v);
        sbi.WB_wrEn    = 1'b1;
        sbi.WB_rD      = d;
        sbi.WB_ppp     = p;
        sbi.WB_rD_data = v;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        // Reset state
        rd(0, 5'd1, 1'b1); rd(1, 5'd2, 1'b1);
        want(K_STL, "rst_stall", 64'd0);
        want(K_RD0, "rst_rd0", 64'd0);
        want(K_RD1, "rst_rd1", 64'd0);
        want(K_ERR, "rst_err", 64'd0);
        step();
        reset = 1'b0;

        // Byte lanes on r5
        idle(); iss(5'd5); want(K_STL, "iss_r5", 64'd0); step();
        idle(); wb(5'd5, 3'b000, 64'h0011223344556677); iss(5'd5);
        want(K_STL, "iss_wb_r5", 64'd0); step();
        idle(); wb(5'd5, 3'b011, 64'hFFFFFFFFFFFFFFFF); rd(1, 5'd5, 1'b1);
        want(K_RD1, "wt_even", 64'hFF11FF33FF55FF77);
        want(K_STL, "wt_even_stall", 64'd0); step();
        idle(); rd(0, 5'd5, 1'b1);
        want(K_RD0, "r5_lanes", 64'hFF11FF33FF55FF77);
        want(K_STL, "r5_nostall", 64'd0);
        want(K_ERR, "r5_noerr", 64'd0); step();

        // Write-through and remaining lane selects on r7
        idle(); iss(5'd7); step();
        idle(); wb(5'd7, 3'b010, 64'hAAAAAAAABBBBBBBB); rd(1, 5'd7, 1'b0);
        want(K_RD1, "wt_lower", 64'h00000000BBBBBBBB); step();
        idle(); iss(5'd7); rd(0, 5'd7, 1'b1);
        want(K_RD0, "r7_lower", 64'h00000000BBBBBBBB);
        want(K_STL, "iss_no_self", 64'd0); step();
        idle(); wb(5'd7, 3'b001, 64'h1111111122222222); rd(0, 5'd7, 1'b0);
        want(K_RD0, "wt_upper", 64'h11111111BBBBBBBB); step();
        idle(); iss(5'd7); step();
        idle(); wb(5'd7, 3'b100, 64'hCCCCCCCCCCCCCCCC); rd(1, 5'd7, 1'b0);
        want(K_RD1, "wt_odd", 64'h11CC11CCBBCCBBCC); step();
        idle(); iss(5'd7); step();
        idle(); wb(5'd7, 3'b101, 64'hFFFFFFFFFFFFFFFF); rd(0, 5'd7, 1'b1);
        want(K_RD0, "ppp_none", 64'h11CC11CCBBCCBBCC);
        want(K_STL, "ppp_none_wb", 64'd0); step();
        idle(); rd(0, 5'd7, 1'b1);
        want(K_STL, "ppp_none_cnt", 64'd0);
        want(K_ERR, "ppp_none_err", 64'd0); step();

        // RAW stall and bypass on r3; stalled issue to r11 must be dropped
        idle(); iss(5'd3); want(K_STL, "iss_r3", 64'd0); step();
        idle(); rd(0, 5'd3, 1'b1); iss(5'd11);
        want(K_STL, "raw_stall", 64'd1); step();
        idle(); wb(5'd3, 3'b000, 64'hDEADBEEF01234567); rd(0, 5'd3, 1'b1);
        want(K_STL, "wb_release", 64'd0);
        want(K_RD0, "bypass", 64'hDEADBEEF01234567); step();
        idle(); rd(0, 5'd3, 1'b1); rd(1, 5'd11, 1'b1);
        want(K_STL, "stalled_iss_dropped", 64'd0);
        want(K_RD0, "r3_stored", 64'hDEADBEEF01234567); step();

        // Saturation on r9
        for (int n = 0; n < 3; n++) begin
            idle(); iss(5'd9); want(K_STL, "sat_fill", 64'd0); step();
        end
        idle(); iss(5'd9); want(K_STL, "sat_stall", 64'd1); step();
        idle(); iss(5'd9); wb(5'd9, 3'b000, 64'h9);
        want(K_STL, "sat_wb", 64'd0); step();
        idle(); iss(5'd9); want(K_STL, "sat_hold", 64'd1); step();
        idle(); wb(5'd9, 3'b000, 64'h9); rd(0, 5'd9, 1'b1);
        want(K_STL, "drain1", 64'd1); step();
        idle(); wb(5'd9, 3'b000, 64'h9); step();
        idle(); wb(5'd9, 3'b000, 64'h9); rd(0, 5'd9, 1'b1);
        want(K_STL, "drain3", 64'd0); step();
        idle(); rd(0, 5'd9, 1'b1);
        want(K_STL, "drained", 64'd0);
        want(K_ERR, "drain_noerr", 64'd0); step();

        // r0 and error flag
        idle(); wb(5'd0, 3'b000, 64'h1234); rd(1, 5'd0, 1'b1);
        want(K_RD1, "r0_wt", 64'd0);
        want(K_STL, "r0_wb_stall", 64'd0); step();
        idle(); rd(0, 5'd0, 1'b1);
        want(K_RD0, "r0_read", 64'd0);
        want(K_ERR, "r0_no_err", 64'd0); step();
        idle(); iss(5'd0); rd(1, 5'd0, 1'b1); want(K_STL, "r0_iss", 64'd0); step();
        idle(); rd(0, 5'd0, 1'b1); want(K_STL, "r0_untracked", 64'd0); step();
        idle(); wb(5'd4, 3'b000, 64'h44); want(K_ERR, "err_pre", 64'd0); step();
        idle(); rd(0, 5'd4, 1'b1);
        want(K_ERR, "err_set", 64'd1);
        want(K_STL, "err_no_wrap", 64'd0); step();
        for (int n = 0; n < 2; n++) begin
            idle(); want(K_ERR, "err_sticky", 64'd1); step();
        end

        // Reset mid-operation with r2 pending
        idle(); iss(5'd2); step();
        idle(); iss(5'd2); step();
        idle(); rd(0, 5'd2, 1'b1); want(K_STL, "r2_pending", 64'd1); step();
        reset = 1'b1;
        idle(); iss(5'd2); wb(5'd2, 3'b000, 64'h2222); rd(0, 5'd2, 1'b1);
        want(K_STL, "stall_in_reset", 64'd1); step();
        reset = 1'b0;
        idle(); rd(0, 5'd2, 1'b1); rd(1, 5'd5, 1'b1);
        want(K_STL, "post_rst_stall", 64'd0);
        want(K_RD0, "post_rst_rd0", 64'd0);
        want(K_RD1, "post_rst_rd1", 64'd0);
        want(K_ERR, "post_rst_err", 64'd0); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
